// File: rtl/ll_multi_fifo_pkg.sv
// Shared definitions for the linked-list multi-queue: sticky flag bit indices and select check.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package ll_fifo_pkg;

    localparam int FLAG_OVERFLOW  = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int NUM_FLAGS      = 2;

    // A queue select is usable only when it names an existing queue.
    function automatic logic sel_valid(input int unsigned sel, input int unsigned num_fifos);
        return sel < num_fifos;
    endfunction

endpackage

// File: rtl/ll_multi_fifo_if.sv
// Push/pop request bundle and status outputs of the shared-buffer multi-queue.
// Latency: wires only; timing is set by the module behind the slave modport.
// Backpressure: the master must watch full/empty; illegal requests are dropped and flagged.
interface ll_multi_fifo_if #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int NUM_FIFOS = 2,
    parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
);
    logic                           push;
    logic [SEL_WIDTH-1:0]           push_sel;
    logic [WIDTH-1:0]               data_in;
    logic                           pop;
    logic [SEL_WIDTH-1:0]           pop_sel;
    logic [WIDTH-1:0]               data_out;
    logic [NUM_FIFOS-1:0]           empty;
    logic                           full;
    logic [NUM_FIFOS*CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0]           free_count;
    logic                           overflow;
    logic                           underflow;

    modport master (
        output push, push_sel, data_in, pop, pop_sel,
        input  data_out, empty, full, count, free_count, overflow, underflow
    );

    modport slave (
        input  push, push_sel, data_in, pop, pop_sel,
        output data_out, empty, full, count, free_count, overflow, underflow
    );
endinterface

// File: rtl/ll_multi_fifo_free_list.sv
// Circular ring of free entry indices; hands out one index per alloc, takes one back per free.
// Latency: allocated index is combinational from state; ring pointers update on the next edge.
// Backpressure: o_empty says nothing can be allocated; the caller must not alloc then.
module ll_free_list #(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_alloc,
    output logic [PTR_WIDTH-1:0] o_alloc_ptr,
    input  logic                 i_free,
    input  logic [PTR_WIDTH-1:0] i_free_ptr,
    output logic                 o_empty,
    output logic [CNT_WIDTH-1:0] o_count
);
    localparam logic [PTR_WIDTH:0] PTR_ONE = 1;

    logic [PTR_WIDTH-1:0] r_fl_mem [DEPTH];
    logic [PTR_WIDTH:0]   r_fl_rd;
    logic [PTR_WIDTH:0]   r_fl_wr;
    logic [PTR_WIDTH:0]   w_diff;

    // Ring starts as the identity list with every entry free; the extra pointer MSB tells full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fl_mem[i] <= PTR_WIDTH'(i);
            end
            r_fl_rd <= '0;
            r_fl_wr <= (PTR_WIDTH + 1)'(DEPTH);
        end else begin
            if (i_alloc) begin
                r_fl_rd <= r_fl_rd + PTR_ONE;
            end
            if (i_free) begin
                r_fl_mem[r_fl_wr[PTR_WIDTH-1:0]] <= i_free_ptr;
                r_fl_wr                          <= r_fl_wr + PTR_ONE;
            end
        end
    end

    // Status and the next index to hand out, straight from the ring state.
    always_comb begin
        w_diff      = r_fl_wr - r_fl_rd;
        o_count     = CNT_WIDTH'(w_diff);
        o_empty     = (r_fl_rd == r_fl_wr);
        o_alloc_ptr = r_fl_mem[r_fl_rd[PTR_WIDTH-1:0]];
    end
endmodule

// File: rtl/ll_multi_fifo.sv
// NUM_FIFOS logical queues sharing one DEPTH-entry store via per-entry next pointers and a free list.
// Latency: pushed word visible at head one cycle after the push edge; head output is fall-through.
// Backpressure: push refused while full, pop refused on an empty queue; refusals set sticky flags.
module ll_multi_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int NUM_FIFOS = 2,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    ll_multi_fifo_if.slave bus
);
    import ll_fifo_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0]     r_data_mem [DEPTH];
    logic [PTR_WIDTH-1:0] r_next_ptr [DEPTH];
    logic [PTR_WIDTH-1:0] r_head     [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] r_tail     [NUM_FIFOS];
    logic [CNT_WIDTH-1:0] r_cnt      [NUM_FIFOS];
    logic [NUM_FLAGS-1:0] r_flags;

    logic                 w_push_sel_ok;
    logic                 w_pop_sel_ok;
    logic [SEL_WIDTH-1:0] w_push_idx;
    logic [SEL_WIDTH-1:0] w_pop_idx;
    logic                 w_push_ok;
    logic                 w_pop_ok;
    logic                 w_same_q;
    logic                 w_push_to_empty;
    logic [NUM_FIFOS-1:0] w_push_hit;
    logic [NUM_FIFOS-1:0] w_pop_hit;
    logic [PTR_WIDTH-1:0] w_new;
    logic                 w_fl_empty;
    logic [CNT_WIDTH-1:0] w_free_count;

    ll_free_list #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_free_list (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_alloc     (w_push_ok),
        .o_alloc_ptr (w_new),
        .i_free      (w_pop_ok),
        .i_free_ptr  (r_head[w_pop_idx]),
        .o_empty     (w_fl_empty),
        .o_count     (w_free_count)
    );

    // Legality from start-of-cycle state only: a same-cycle pop never makes room for a push,
    // and a same-cycle push never makes an empty queue poppable.
    always_comb begin
        w_push_sel_ok   = sel_valid(32'(bus.push_sel), NUM_FIFOS);
        w_pop_sel_ok    = sel_valid(32'(bus.pop_sel), NUM_FIFOS);
        w_push_idx      = w_push_sel_ok ? bus.push_sel : '0;
        w_pop_idx       = w_pop_sel_ok ? bus.pop_sel : '0;
        w_push_ok       = bus.push && w_push_sel_ok && !w_fl_empty;
        w_pop_ok        = bus.pop && w_pop_sel_ok && (r_cnt[w_pop_idx] != '0);
        w_same_q        = w_push_ok && w_pop_ok && (w_push_idx == w_pop_idx);
        // The push target ends up with no older entry: it was empty, or its only entry leaves now.
        w_push_to_empty = (r_cnt[w_push_idx] == '0) ||
                          (w_same_q && (r_cnt[w_push_idx] == CNT_ONE));
        for (int q = 0; q < NUM_FIFOS; q++) begin
            w_push_hit[q] = w_push_ok && (w_push_idx == SEL_WIDTH'(q));
            w_pop_hit[q]  = w_pop_ok && (w_pop_idx == SEL_WIDTH'(q));
        end
    end

    // Payload and link storage; contents only matter once an entry is allocated, so no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_data_mem[w_new] <= bus.data_in;
            if (!w_push_to_empty) begin
                r_next_ptr[r_tail[w_push_idx]] <= w_new;
            end
        end
    end

    // Per-queue head/tail/count; a push into a queue left empty overrides the pop's head advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < NUM_FIFOS; q++) begin
                r_head[q] <= '0;
                r_tail[q] <= '0;
                r_cnt[q]  <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_FIFOS; q++) begin
                if (w_pop_hit[q]) begin
                    r_head[q] <= r_next_ptr[r_head[q]];
                end
                if (w_push_hit[q]) begin
                    r_tail[q] <= w_new;
                    if (w_push_to_empty) begin
                        r_head[q] <= w_new;
                    end
                end
                if (w_push_hit[q] && !w_pop_hit[q]) begin
                    r_cnt[q] <= r_cnt[q] + CNT_ONE;
                end else if (!w_push_hit[q] && w_pop_hit[q]) begin
                    r_cnt[q] <= r_cnt[q] - CNT_ONE;
                end
            end
        end
    end

    // Sticky error flags: any refused request latches until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else begin
            if (bus.push && !w_push_ok) begin
                r_flags[FLAG_OVERFLOW] <= 1'b1;
            end
            if (bus.pop && !w_pop_ok) begin
                r_flags[FLAG_UNDERFLOW] <= 1'b1;
            end
        end
    end

    // Status outputs from state; data_out is the fall-through head of the selected queue.
    always_comb begin
        bus.empty = '0;
        bus.count = '0;
        for (int q = 0; q < NUM_FIFOS; q++) begin
            bus.empty[q]                       = (r_cnt[q] == '0);
            bus.count[q*CNT_WIDTH +: CNT_WIDTH] = r_cnt[q];
        end
        bus.data_out   = (w_pop_sel_ok && (r_cnt[w_pop_idx] != '0)) ?
                         r_data_mem[r_head[w_pop_idx]] : '0;
        bus.full       = w_fl_empty;
        bus.free_count = w_free_count;
        bus.overflow   = r_flags[FLAG_OVERFLOW];
        bus.underflow  = r_flags[FLAG_UNDERFLOW];
    end
endmodule

// File: tb/tb_ll_multi_fifo.sv
// Scoreboard bench for ll_multi_fifo: a 2-queue and a 3-queue instance share clock and reset.
// Inputs change 1 time unit after the rising edge; the monitor compares on the falling edge.
// Expected pop data and status values are queued by the stimulus and drained by the monitor.
module tb_ll_multi_fifo;
    localparam int DEPTH = 4;

    typedef struct {
        int          field;
        logic [31:0] val;
    } st_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pop_legal = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_data_q[$];
    st_t        st_q[$];

    ll_multi_fifo_if #(.WIDTH(8), .DEPTH(DEPTH), .NUM_FIFOS(2)) b2();
    ll_multi_fifo_if #(.WIDTH(8), .DEPTH(DEPTH), .NUM_FIFOS(3)) b3();

    ll_multi_fifo #(.WIDTH(8), .DEPTH(DEPTH), .NUM_FIFOS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );
    ll_multi_fifo #(.WIDTH(8), .DEPTH(DEPTH), .NUM_FIFOS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b3)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] field_val(input int f);
        case (f)
            0:       return 32'(b2.data_out);
            1:       return 32'(b2.empty);
            2:       return 32'(b2.full);
            3:       return 32'(b2.free_count);
            4:       return 32'(b2.overflow);
            5:       return 32'(b2.underflow);
            6:       return 32'(b2.count[2:0]);
            7:       return 32'(b2.count[5:3]);
            10:      return 32'(b3.data_out);
            11:      return 32'(b3.empty);
            14:      return 32'(b3.overflow);
            default: return 32'(b3.underflow);
        endcase
    endfunction

    function automatic string field_name(input int f);
        case (f)
            0:       return "data_out";
            1:       return "empty";
            2:       return "full";
            3:       return "free_count";
            4:       return "overflow";
            5:       return "underflow";
            6:       return "count_q0";
            7:       return "count_q1";
            10:      return "q3_data_out";
            11:      return "q3_empty";
            14:      return "q3_overflow";
            default: return "q3_underflow";
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: drain queued status expectations, score popped words, check the entry invariant.
    always @(negedge clk) begin
        st_t s;
        while (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk(field_name(s.field), field_val(s.field), s.val);
        end
        if (rst_n && b2.pop && pop_legal) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_data: got 0x%0h with no expected word queued", b2.data_out);
            end else begin
                chk("pop_data", 32'(b2.data_out), 32'(exp_data_q.pop_front()));
            end
        end
        if (rst_n) begin
            chk("free_invariant",
                32'(b2.free_count) + 32'(b2.count[2:0]) + 32'(b2.count[5:3]), DEPTH);
        end
    end

    task automatic expect_st(input int f, input logic [31:0] v);
        st_t s;
        s.field = f;
        s.val   = v;
        st_q.push_back(s);
    endtask

    task automatic step(input logic pu, input int ps, input logic [7:0] d,
                        input logic po, input int pos, input logic legal, input logic [7:0] ed);
        @(posedge clk);
        #1;
        b2.push     = pu;
        b2.push_sel = ps[0];
        b2.data_in  = d;
        b2.pop      = po;
        b2.pop_sel  = pos[0];
        pop_legal   = legal;
        if (legal) exp_data_q.push_back(ed);
    endtask

    task automatic idle(input int pos);
        step(1'b0, 0, 8'h00, 1'b0, pos, 1'b0, 8'h00);
    endtask

    // Reset asserted mid-cycle; status is checked while reset is still low, then released.
    task automatic do_reset();
        @(posedge clk);
        #1;
        b2.push = 1'b0; b2.pop = 1'b0; pop_legal = 1'b0;
        b3.push = 1'b0; b3.pop = 1'b0;
        rst_n = 1'b0;
        expect_st(1, 32'h3);
        expect_st(3, 4);
        expect_st(4, 0);
        expect_st(6, 0);
        expect_st(7, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [7:0] mm [2][DEPTH];
    int mrd[2], mwr[2], mc[2];

    initial begin
        b2.push = 1'b0; b2.push_sel = '0; b2.data_in = '0; b2.pop = 1'b0; b2.pop_sel = '0;
        b3.push = 1'b0; b3.push_sel = '0; b3.data_in = '0; b3.pop = 1'b0; b3.pop_sel = '0;
        do_reset();

        // Reset state.
        idle(0);
        expect_st(0, 0); expect_st(1, 32'h3); expect_st(2, 0); expect_st(3, 4);
        expect_st(4, 0); expect_st(5, 0); expect_st(6, 0); expect_st(7, 0);

        // Basic ordering across two queues.
        step(1, 0, 8'hA1, 0, 0, 0, 0);
        step(1, 0, 8'hA2, 0, 0, 0, 0);
        step(1, 1, 8'hB1, 0, 0, 0, 0);
        idle(0);
        expect_st(0, 32'hA1); expect_st(6, 2); expect_st(7, 1); expect_st(3, 1);
        step(0, 0, 0, 1, 0, 1, 8'hA1);
        step(0, 0, 0, 1, 0, 1, 8'hA2);
        step(0, 0, 0, 1, 1, 1, 8'hB1);
        idle(0);
        expect_st(1, 32'h3); expect_st(3, 4); expect_st(0, 0);

        // Fill, overflow, and a pop that cannot make room for a same-cycle push.
        step(1, 0, 8'h01, 0, 0, 0, 0);
        step(1, 1, 8'h02, 0, 0, 0, 0);
        step(1, 0, 8'h03, 0, 0, 0, 0);
        step(1, 1, 8'h04, 0, 0, 0, 0);
        idle(0);
        expect_st(2, 1); expect_st(3, 0); expect_st(6, 2); expect_st(7, 2); expect_st(0, 32'h01);
        step(1, 0, 8'h05, 0, 0, 0, 0);
        idle(0);
        expect_st(4, 1); expect_st(6, 2); expect_st(7, 2); expect_st(3, 0);
        step(1, 1, 8'h06, 1, 0, 1, 8'h01);
        idle(0);
        expect_st(6, 1); expect_st(7, 2); expect_st(3, 1); expect_st(2, 0); expect_st(0, 32'h03);
        do_reset();
        idle(0);
        expect_st(4, 0); expect_st(5, 0); expect_st(2, 0); expect_st(0, 0);

        // Pop of empty q1 with same-cycle push to q1.
        step(1, 1, 8'h33, 1, 1, 0, 0);
        idle(1);
        expect_st(5, 1); expect_st(7, 1); expect_st(0, 32'h33); expect_st(4, 0);
        step(0, 0, 0, 1, 1, 1, 8'h33);
        idle(1);
        expect_st(7, 0); expect_st(0, 0);

        // Same-queue push and pop with a single resident entry.
        step(1, 0, 8'h11, 0, 0, 0, 0);
        idle(0);
        expect_st(3, 3); expect_st(0, 32'h11);
        step(1, 0, 8'h22, 1, 0, 1, 8'h11);
        idle(0);
        expect_st(6, 1); expect_st(0, 32'h22); expect_st(3, 3);
        step(0, 0, 0, 1, 0, 1, 8'h22);
        idle(0);
        expect_st(6, 0); expect_st(1, 32'h3);

        // Three-queue instance: out-of-range selects.
        @(posedge clk); #1;
        b3.pop = 1'b1; b3.pop_sel = 2'd3;
        expect_st(10, 0);
        @(posedge clk); #1;
        b3.pop = 1'b0;
        expect_st(15, 1); expect_st(14, 0);
        b3.push = 1'b1; b3.push_sel = 2'd3; b3.data_in = 8'h5A;
        @(posedge clk); #1;
        b3.push_sel = 2'd2; b3.data_in = 8'h77;
        expect_st(14, 1);
        @(posedge clk); #1;
        b3.push = 1'b0; b3.pop_sel = 2'd2;
        expect_st(10, 32'h77); expect_st(11, 32'h3);

        // Random legal/illegal traffic against per-queue circular FIFO models.
        do_reset();
        for (int q = 0; q < 2; q++) begin
            mrd[q] = 0; mwr[q] = 0; mc[q] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            int pu, ps, po, pos, tot;
            logic [7:0] d;
            logic pu_ok, po_ok;
            pu  = $urandom_range(0, 1);
            ps  = $urandom_range(0, 1);
            po  = $urandom_range(0, 1);
            pos = $urandom_range(0, 1);
            d   = 8'($urandom);
            tot   = mc[0] + mc[1];
            pu_ok = (pu != 0) && (tot != DEPTH);
            po_ok = (po != 0) && (mc[pos] > 0);
            step(pu[0], ps, d, po[0], pos, po_ok, po_ok ? mm[pos][mrd[pos]] : 8'h00);
            expect_st(0, (mc[pos] > 0) ? 32'(mm[pos][mrd[pos]]) : 32'h0);
            expect_st(1, 32'({mc[1] == 0, mc[0] == 0}));
            expect_st(3, 32'(DEPTH - tot));
            if (po_ok) begin
                mrd[pos] = (mrd[pos] + 1) % DEPTH;
                mc[pos]--;
            end
            if (pu_ok) begin
                mm[ps][mwr[ps]] = d;
                mwr[ps] = (mwr[ps] + 1) % DEPTH;
                mc[ps]++;
            end
        end
        idle(0);
        idle(0);
        @(posedge clk);
        checks++;
        if (exp_data_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_pops: got %0d unconsumed expected words, expected 0",
                     exp_data_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ll_multi_fifo.md
# ll_multi_fifo

Parametrised shared-buffer multi-queue: NUM_FIFOS logical FIFOs share one DEPTH-entry data store, linked through a per-entry next-pointer array and fed by an internal free list. It is the next generation of the linked-list shared FIFO used in the equivalence-proof flow. It adds:
- same-cycle push and pop (any queue pair);
- per-queue occupancy counts;
- a free-entry count;
- sticky overflow/underflow error flags.

Each logical queue must remain observably equivalent to a private circular-pointer FIFO of depth DEPTH.

## Interface
Parameters:
- WIDTH, 8, data bits per entry
- DEPTH, 4, shared entries; power of two, ≥2
- NUM_FIFOS, 2, logical queues, ≥1
- PTR_WIDTH, $clog2(DEPTH), entry index width
- SEL_WIDTH, max(1,$clog2(NUM_FIFOS)), queue select width
- CNT_WIDTH, $clog2(DEPTH+1), count width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- push  in  1  enqueue request
- push_sel  in  SEL_WIDTH  target queue for push
- data_in  in  WIDTH  enqueue data
- pop  in  1  dequeue request
- pop_sel  in  SEL_WIDTH  source queue for pop; also selects data_out
- data_out  out  WIDTH  head of queue pop_sel (first-word fall-through); 0 when that queue is empty or pop_sel is invalid
- empty  out  NUM_FIFOS  bit i = queue i holds no entries
- full  out  1  free list empty (no entry allocatable)
- count  out  NUM_FIFOS*CNT_WIDTH  per-queue occupancy, queue i at [i*CNT_WIDTH +: CNT_WIDTH]
- free_count  out  CNT_WIDTH  free entries
- overflow  out  1  sticky: illegal push seen
- underflow  out  1  sticky: illegal pop seen

## Operation
- State: data_mem[DEPTH]; next_ptr[DEPTH]; per-queue head, tail, cnt; free-list pointer ring fl_mem[DEPTH] with fl_rd and fl_wr, each PTR_WIDTH+1 bits.
- Reset (async assert; deassert sampled on clk): fl_mem[i]=i, fl_rd=0, fl_wr=DEPTH. Resulting outputs: all cnt=0, empty all ones, full=0, free_count=DEPTH, overflow=0, underflow=0, data_out=0. data_mem and next_ptr are not reset.
- Legal push: push & !full & push_sel<NUM_FIFOS.
  - new = fl_mem[fl_rd]; data_mem[new]<=data_in; fl_rd++.
  - If queue empty (after any same-cycle pop), head<=new; otherwise next_ptr[tail]<=new.
  - tail<=new; cnt++.
- Legal pop: pop & !empty[pop_sel] & pop_sel<NUM_FIFOS.
  - fl_mem[fl_wr]<=head; fl_wr++; head<=next_ptr[head]; cnt--.
- Same queue, push and pop, cnt==1: head<=new, tail<=new, cnt stays 1.
- Different queues: both proceed independently.
- Push and pop both legal with full=1 cannot occur (full implies every queue's entries are allocated; pop is legal, push is not).
- No bypass; the full/empty status sampled at the start of the cycle decides legality:
  - push while full is rejected even if a pop frees an entry that cycle;
  - pop from an empty queue is rejected even if a push targets it that cycle.
- Illegal push: no state change; overflow<=1.
- Illegal pop: no state change; underflow<=1.
- Sticky flags clear only on reset.
- Invariant: free_count + Σcount == DEPTH at all times.

## Timing
- Outputs are combinational from state only: data_out, empty, full, count, free_count (no input-to-output paths except pop_sel→data_out mux).
- Push of data D at edge k: D is visible on data_out at cycle k+1 when the queue was empty and pop_sel selects it.
- Pop at edge k: the next entry appears on data_out in cycle k+1.
- full = (fl_rd==fl_wr).
- free_count = fl_wr - fl_rd, modulo 2^(PTR_WIDTH+1).
- Pointer wrap-around uses the extra MSB; fl_mem is indexed by the low PTR_WIDTH bits.
- rst_n asserted mid-operation: all queues drop to empty in the same cycle; data in flight is discarded.

## Structure
- Package ll_fifo_pkg holds the shared flag bit indices and the helper function sel_valid(sel, NUM_FIFOS).
- Sub-module ll_free_list: a circular pointer ring with alloc/free ports, full/empty, and count, reset to the identity list.
- Top level holds data_mem, next_ptr, and the per-queue head/tail/cnt state.
- Expected RTL size: about 250 lines.

## Test plan
- Reset, then push 0xA1,0xA2 to q0 and 0xB1 to q1, then pop q0 twice and q1 once → data_out sequence 0xA1,0xA2,0xB1; empty=2'b11; free_count=4.
- Fill all 4 entries interleaving q0/q1 → full=1 and free_count=0. A fifth push → overflow=1 and no count changes. Reset → overflow=0.
- Pop from an empty q1 with a same-cycle push to q1 → underflow=1, count[q1]=1 afterwards, data_out shows the pushed word.
- q0 holds 1 entry (0x11); same-cycle push 0x22/pop q0 → count[q0]=1, data_out=0x22 next cycle, free_count unchanged.
- Random legal push/pop for 10k cycles against a per-queue circular-pointer FIFO model → data_out and empty match every cycle; the free_count invariant holds.
- NUM_FIFOS=3 build: pop_sel=3 → data_out=0 and underflow=1; push_sel=3 → overflow=1.
